// File: rtl/ok_pipe_out_fifo.sv
// ---------------------------------------------------------------------------
// ok_pipe_out_fifo
//
// Host-read ("Output Pipe") endpoint. User logic pushes 32-bit words into an
// internal first-word-fall-through FIFO. Host reads addressed to ep_addr pop
// words onto the okEH bus.
//
// Bus field layout used here:
//   okHE[0]      ti_clk   (mirrored; the dedicated ti_clk port clocks the block)
//   okHE[1]      ti_reset (mirrored; the dedicated ti_reset port resets the block)
//   okHE[2]      ti_write (not used by an output pipe)
//   okHE[3]      ti_read
//   okHE[11:4]   ti_addr
//   okHE[112:12] other host fields (unused here)
//   okEH[31:0]   DATA        FIFO head when addressed and not empty, else 0
//   okEH[32]     READY       ti_addr == ep_addr
//   okEH[64:33]  REGREADDATA tied to 0
//
// Handshake: a pop happens on a rising ti_clk edge where ti_read is high,
// ti_addr matches ep_addr and the FIFO is not empty. The head word is already
// on DATA during that cycle (zero added latency); the next word appears the
// following cycle. A push happens on an edge with wr_en high when the FIFO is
// not full, or when it is full but a pop occurs on the same edge. A push
// into a full FIFO without a pop is dropped.
//
// Ports:
//   ti_clk, ti_reset      clock and synchronous active-high reset
//   okHE / okEH           host bus in / endpoint bus out
//   ep_addr               endpoint address
//   wr_en, wr_data        user push strobe and data
//   full, almost_full,
//   empty, level          occupancy flags derived from the registered level
//   status[1:0]           {overflow, underrun} sticky flags, only when
//                         OK_PIPE_OUT_FIFO_STATUS_EN is defined
//
// Configuration macro: OK_PIPE_OUT_FIFO_STATUS_EN
// ---------------------------------------------------------------------------
module ok_pipe_out_fifo #(
  parameter int DEPTH_LOG2  = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                  ti_clk,
  input  logic                  ti_reset,
  input  logic [112:0]          okHE,
  output logic [64:0]           okEH,
  input  logic [7:0]            ep_addr,
  input  logic                  wr_en,
  input  logic [31:0]           wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
`ifdef OK_PIPE_OUT_FIFO_STATUS_EN
  ,
  output logic [1:0]            status
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_L = LW'(AFULL_LEVEL);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  // Host bus decode
  logic       ti_read;
  logic [7:0] ti_addr;
  logic       addr_hit;

  assign ti_read  = okHE[3];
  assign ti_addr  = okHE[11:4];
  assign addr_hit = (ti_addr == ep_addr);

  // Fields this endpoint does not consume
  logic unused_okhe;
  assign unused_okhe = ^{okHE[112:12], okHE[2:0]};

  // State
  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;

  logic pop;
  logic push;

  // Flags come from the registered level only
  assign empty       = (level_q == '0);
  assign full        = (level_q == DEPTH_L);
  assign almost_full = (level_q >= AFULL_L);
  assign level       = level_q;

  // A pop frees a slot on the same edge, so a full FIFO can still accept a
  // push when it is being read. A read while empty never bypasses a push.
  assign pop  = ti_read && addr_hit && !empty;
  assign push = wr_en && (!full || pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    level_d = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge ti_clk) begin
    if (ti_reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not cleared by reset; the pointers define what is valid.
  always_ff @(posedge ti_clk) begin
    if (push && !ti_reset) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Endpoint -> host bus
  logic [31:0] eh_data;

  always_comb begin
    eh_data = 32'h0;
    if (addr_hit && !empty) begin
      eh_data = mem_q[rd_ptr_q];
    end
  end

  assign okEH = {32'h0, addr_hit, eh_data};

`ifdef OK_PIPE_OUT_FIFO_STATUS_EN
  // Sticky error flags, cleared only by reset
  logic overflow_q, overflow_d;
  logic underrun_q, underrun_d;

  always_comb begin
    overflow_d = overflow_q;
    underrun_d = underrun_q;
    if (wr_en && !push) begin
      overflow_d = 1'b1;
    end
    if (ti_read && addr_hit && empty) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge ti_clk) begin
    if (ti_reset) begin
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      underrun_q <= underrun_d;
    end
  end

  assign status = {overflow_q, underrun_q};
`endif

endmodule
